bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 12, binary input width; legal range 1..32.
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD output digits; legal range 1..10.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-006 SHALL have port biner  input  BIN_W  unsigned binary value, sampled on the edge that accepts start.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse when bcd holds a new result.
REQ-009 SHALL have port bcd  output  4*DIGITS  result; digit i at bits [4i+3:4i]; digit 0 is the units digit.
REQ-010 SHALL have port overflow  output  1  high when the last converted value exceeded DIGITS digits.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE: start=1 at an edge SHALL capture biner, clear the digit scratch registers, load the bit counter with BIN_W-1, and enter SHIFT; busy=1 from that edge.
REQ-013 SHIFT: each cycle SHALL add 3 to every scratch digit >=5, then shift the whole {digits, remaining binary} vector left one bit, MSB of the binary first.
REQ-014 SHIFT SHALL last exactly BIN_W cycles; after the final shift, it SHALL enter DONE.
REQ-015 On entry to DONE, bcd and overflow SHALL update; done=1 and busy=0 for exactly one cycle; the next state SHALL be IDLE.
REQ-016 Latency: start accepted at edge k -> done high in the cycle after edge k+BIN_W+1; throughput is one conversion per BIN_W+2 cycles.
REQ-017 start while busy=1, or while in DONE, SHALL be ignored and not queued.
REQ-018 biner changes after capture SHALL NOT affect the conversion in progress.
REQ-019 bcd and overflow SHALL hold their last values until the next DONE.
REQ-020 If the captured value >= 10^DIGITS, overflow SHALL be 1 and bcd SHALL saturate to all digits 9; otherwise overflow=0 and bcd equals the exact decimal value.
REQ-021 Scratch digit width SHALL be 4 bits; the add-3 adjust SHALL never carry out of a digit.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, busy=0, done=0, overflow=0, bcd=0, and clear the counter and scratch; rst SHALL take priority over start.
REQ-023 rst during SHIFT SHALL abort the conversion with no done pulse; bcd SHALL read 0.

Configuration
REQ-024 With macro BCD_BLANK_EN defined, the block SHALL add output blank (DIGITS bits): bit i=1 when digit i and all higher digits are 0, except bit 0, which is always 0; blank SHALL update with bcd and reset to all-ones except bit 0.
REQ-025 Without BCD_BLANK_EN, the blank port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package bcd_pkg SHALL hold the FSM state typedef, DIGIT_W=4, and a constant function pow10(n) used for the overflow bound.
REQ-027 One sub-module, bcd_digit_adj (4-bit in, 4-bit out, add 3 if >=5, combinational), SHALL be instantiated DIGITS times.

Verification
REQ-028 Defaults, biner=12'd4095, start pulse -> done after 14 cycles; bcd=16'h4095; overflow=0.
REQ-029 Defaults, biner=0 -> bcd=16'h0000; overflow=0; with BCD_BLANK_EN, blank=4'b1110.
REQ-030 BIN_W=12, DIGITS=3, biner=1234 -> overflow=1; bcd=12'h999.
REQ-031 start held high continuously with biner=250 then 999 -> one done every 14 cycles; no start accepted while busy.
REQ-032 rst asserted in the 5th SHIFT cycle of biner=777 -> no done pulse; busy=0 and bcd=0 next cycle; a subsequent start of 777 -> bcd=16'h0777.
REQ-033 Exhaustive sweep, biner=0..4095 with defaults -> every bcd matches the reference decimal model.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   state_t  - converter FSM state encoding (IDLE, SHIFT, DONE)
//   DIGIT_W  - width of one BCD digit (4)
//   pow10(n) - constant 10**n, used for the decimal overflow bound
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // 64-bit result so that 10**10 (DIGITS max) does not wrap.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5, so
// that the following left shift carries correctly into the next digit.
// Inputs 0..9 map to 0..12, so the result always fits in one digit.
// Ports:
//   din  - scratch digit before the shift
//   dout - corrected digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        if (din >= DIGIT_W'(5)) begin
            dout = din + DIGIT_W'(3);
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential shift-and-add-3 (double dabble) binary to BCD converter.
// A start in IDLE captures biner; BIN_W SHIFT cycles follow, then one DONE
// cycle publishes the result, and done pulses in the cycle after that.
// Values that need more than DIGITS digits saturate bcd to all nines and
// raise overflow.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   start    - conversion request, only honoured in IDLE
//   biner    - unsigned binary input, captured when start is accepted
//   busy     - conversion in progress
//   done     - one-cycle pulse when bcd/overflow carry a new result
//   bcd      - result, digit i at [4i+3:4i], digit 0 = units
//   overflow - last converted value did not fit in DIGITS digits
//   blank    - (only with macro BCD_BLANK_EN) leading-zero blanking mask,
//              bit i set when digit i and all higher digits are zero;
//              bit 0 is never set
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          biner,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      overflow
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]         blank
`endif
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam longint unsigned LIMIT = pow10(DIGITS);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   scr;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   result;
    logic               ovf_cap;
    logic [BCD_W+BIN_W-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scr[g*DIGIT_W +: DIGIT_W]),
            .dout (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected digits and remaining binary shift together as one vector.
    assign shifted = {adj, bin_sr} << 1;

    always_comb begin
        if (ovf_cap) begin
            result = {DIGITS{4'h9}};
        end else begin
            result = scr;
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              all_zero;

    always_comb begin
        blank_nx = '0;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            all_zero = all_zero && (result[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] == '0);
            blank_nx[DIGITS-1-i] = all_zero;
        end
        blank_nx[0] = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            cnt      <= '0;
            scr      <= '0;
            bin_sr   <= '0;
            ovf_cap  <= 1'b0;
`ifdef BCD_BLANK_EN
            blank    <= '1;
            blank[0] <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= biner;
                        scr     <= '0;
                        cnt     <= CNT_W'(BIN_W - 1);
                        ovf_cap <= (64'(biner) >= LIMIT);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr    <= shifted[BCD_W+BIN_W-1:BIN_W];
                    bin_sr <= shifted[BIN_W-1:0];
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Outputs are registered from the settled scratch, so the
                    // done pulse lands one cycle after the DONE state.
                    bcd      <= result;
                    overflow <= ovf_cap;
`ifdef BCD_BLANK_EN
                    blank    <= blank_nx;
`endif
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
